// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with hex decode, blanking slots
// and a double-buffered display snapshot that only changes on frame edges.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_HZ       = 100000000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic                    load,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode
);

    localparam int DIV   = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]            CAT_OFF = {8{ACTIVE_LOW}};

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
        end
        if (BLANK_CYCLES < 0 || BLANK_CYCLES >= DIV) begin : g_bad_blank
            $error("seg7_scan_driver: BLANK_CYCLES must be below DIV");
        end
    endgenerate

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } phase_e;

    // With no blanking interval every slot begins directly in SHOW
    localparam phase_e START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    phase_e                  phase_q, phase_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [7:0]              cathode_q, cathode_d;
    logic                    fd_q, fd_d;

    logic last_cnt;
    logic frame_end;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= START;
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            pend_en_q  <= '0;
            act_dig_q  <= '0;
            act_dp_q   <= '0;
            act_en_q   <= '0;
            anode_q    <= AN_OFF;
            cathode_q  <= CAT_OFF;
            fd_q       <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            pend_en_q  <= pend_en_d;
            act_dig_q  <= act_dig_d;
            act_dp_q   <= act_dp_d;
            act_en_q   <= act_en_d;
            anode_q    <= anode_d;
            cathode_q  <= cathode_d;
            fd_q       <= fd_d;
        end
    end

    always_comb begin
        last_cnt  = (cnt_q == LAST_CNT);
        frame_end = last_cnt && (idx_q == LAST_IDX);

        cnt_d = last_cnt ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (last_cnt) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        phase_d = phase_q;
        unique case (phase_q)
            BLANK: if (int'(cnt_q) == BLANK_CYCLES - 1) phase_d = SHOW;
            SHOW:  if (last_cnt) phase_d = START;
            default: phase_d = START;
        endcase

        // A load on the commit cycle bypasses straight into active
        pend_dig_d = load ? digits_in : pend_dig_q;
        pend_dp_d  = load ? dp_in     : pend_dp_q;
        pend_en_d  = load ? en_in     : pend_en_q;
        act_dig_d  = frame_end ? pend_dig_d : act_dig_q;
        act_dp_d   = frame_end ? pend_dp_d  : act_dp_q;
        act_en_d   = frame_end ? pend_en_d  : act_en_q;

        fd_d = (cnt_d == LAST_CNT) && (idx_d == LAST_IDX);
    end

    logic [3:0]            nib;
    logic [7:0]            seg;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_on;

    // Pins are computed from next-state so the registers track the count
    always_comb begin
        nib   = act_dig_d[{idx_d, 2'b00} +: 4];
        seg   = {act_dp_d[idx_d], hex7(nib)};
        lit   = (phase_d == SHOW) && act_en_d[idx_d];
        an_on = '0;
        if (lit) begin
            an_on[idx_d] = 1'b1;
        end
        anode_d   = an_on ^ AN_OFF;
        cathode_d = (lit ? seg : 8'h00) ^ CAT_OFF;
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed vector bench for seg7_scan_driver: 4 digits, DIV=4,
// two blanking cycles per slot, active-low pins, 16-cycle frames.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  en_in = '0;
    logic        load = 1'b0;
    logic        frame_done;
    logic [3:0]  anode;
    logic [7:0]  cathode;

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .CLK_HZ      (1600),
        .REFRESH_HZ  (100),
        .BLANK_CYCLES(2),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .en_in     (en_in),
        .load      (load),
        .frame_done(frame_done),
        .anode     (anode),
        .cathode   (cathode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [15:0] an;
        logic [31:0] cat;
    } vec_t;

    vec_t       vecs[18];
    logic [7:0] inv_tab[16];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check("reset_state", {19'd0, anode, cathode, frame_done},
                 {19'd0, 4'hF, 8'hFF, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Called on cycle 0 of a frame; ends on cycle 0 of the next one
    task automatic check_frame(input string nm, input logic [15:0] an,
                               input logic [31:0] cat);
        logic [3:0] ea;
        logic [7:0] ec;
        for (int i = 0; i < 16; i++) begin
            ea = (i % 4 < 2) ? 4'hF : an[(i/4)*4 +: 4];
            ec = (i % 4 < 2) ? 8'hFF : cat[(i/4)*8 +: 8];
            check(nm, {19'd0, anode, cathode, frame_done},
                  {19'd0, ea, ec, (i == 15)});
            check("onehot", 32'($countones(~anode) <= 1), 32'd1);
            step();
        end
    endtask

    task automatic load_and_commit(input logic [15:0] d,
                                   input logic [3:0] dp,
                                   input logic [3:0] en);
        int n;
        digits_in = d;
        dp_in     = dp;
        en_in     = en;
        load      = 1'b1;
        step();
        load = 1'b0;
        n = 0;
        while (!frame_done && n < 40) begin
            step();
            n++;
        end
        check("fd_seen", {31'd0, frame_done}, 32'd1);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        inv_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        vecs[0] = '{16'h1A80, 4'b0100, 4'hF, 16'h7BDE, 32'hF90880C0};
        vecs[1] = '{16'h1A80, 4'b0100, 4'b1010, 16'h7FDF, 32'hF9FF80FF};
        for (int n = 0; n < 16; n++) begin
            vecs[n+2] = '{16'hFFF0 | 16'(n), 4'b0000, 4'b0001,
                          16'hFFFE, {24'hFFFFFF, inv_tab[n]}};
        end

        @(negedge clk);
        do_reset();

        // Idle frames stay dark; a mid-frame load waits for the boundary
        for (int i = 0; i < 64; i++) begin
            check("idle", {19'd0, anode, cathode, frame_done},
                  {19'd0, 4'hF, 8'hFF, (i % 16 == 15)});
            if (i == 50) begin
                digits_in = 16'h1A80;
                dp_in     = 4'b0100;
                en_in     = 4'hF;
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
        end
        check_frame("first_1a80", vecs[0].an, vecs[0].cat);

        for (int v = 0; v < 18; v++) begin
            load_and_commit(vecs[v].dig, vecs[v].dp, vecs[v].en);
            check_frame($sformatf("vec%0d", v), vecs[v].an, vecs[v].cat);
        end

        // Overwritten loads never reach the pins; a commit-cycle load wins
        for (int i = 0; i < 16; i++) begin
            check("no_1_or_2",
                  32'(cathode == 8'hF9 || cathode == 8'hA4), 32'd0);
            load = 1'b0;
            en_in = 4'hF;
            dp_in = 4'b0000;
            if (i == 1) begin
                digits_in = 16'h1111;
                load = 1'b1;
            end else if (i == 5) begin
                digits_in = 16'h2222;
                load = 1'b1;
            end else if (i == 15) begin
                check("fd_commit", {31'd0, frame_done}, 32'd1);
                digits_in = 16'h3333;
                load = 1'b1;
            end
            step();
        end
        load = 1'b0;
        check_frame("threes_a", 16'h7BDE, 32'hB0B0B0B0);
        check_frame("threes_b", 16'h7BDE, 32'hB0B0B0B0);

        // Async reset during slot 2 SHOW, then restart dark
        for (int i = 0; i < 10; i++) step();
        check("pre_rst_slot2", {24'd0, anode, cathode}, {24'd0, 4'hB, 8'hB0});
        do_reset();
        check_frame("post_rst_a", 16'hFFFF, 32'hFFFFFFFF);
        check_frame("post_rst_b", 16'hFFFF, 32'hFFFFFFFF);
        load_and_commit(16'h1A80, 4'b0100, 4'hF);
        check_frame("post_rst_load", vecs[0].an, vecs[0].cat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised time-multiplexed seven-segment driver. It scans NUM_DIGITS common-anode digits at a configurable refresh rate and decodes 4-bit hex values with per-digit decimal points and per-digit enables. Each digit slot starts with a blanking interval to suppress ghosting. Display data is double-buffered so a new value never tears mid-frame. It replaces the fixed 4-digit divider/counter/anode/character chain in the board top level.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
CLK_HZ, 100000000, input clock frequency
REFRESH_HZ, 1000, full-frame refresh rate; slot length DIV = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) cycles
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes and cathodes off; elaboration error unless BLANK_CYCLES < DIV
ACTIVE_LOW, 1, 1 = anode/cathode pins asserted low; 0 = asserted high

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
digits_in  in  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i]
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
en_in  in  NUM_DIGITS  digit enable, 0 = digit dark for its slot
load  in  1  one-cycle strobe that captures digits_in/dp_in/en_in into the pending buffer
frame_done  out  1  one-cycle pulse on the last cycle of the last slot
anode  out  NUM_DIGITS  digit select; one-hot (polarity per ACTIVE_LOW) or all off
cathode  out  8  bit7 = dp, bits 6:0 = g f e d c b a

Behaviour:
- Reset (async, any state): slot counter 0, digit index 0, phase BLANK, pending and active buffers all zero with en = 0, frame_done 0. All anodes and cathodes off: with ACTIVE_LOW=1, anode = all ones and cathode = 8'hFF.
- Slot counter runs 0..DIV-1. Phase BLANK covers counts 0..BLANK_CYCLES-1. Phase SHOW covers counts BLANK_CYCLES..DIV-1.
- FSM transitions:
  - BLANK -> SHOW when count = BLANK_CYCLES-1.
  - SHOW -> BLANK when count = DIV-1; the digit index then increments and wraps NUM_DIGITS-1 -> 0.
- Outputs are registered and reflect the phase of the current count; no combinational path from inputs to pins.
- BLANK phase: all anodes off, cathode all off.
- SHOW phase with active en[idx] = 1: anode[idx] on, all others off; cathode = hex decode of active nibble idx, with dp from active dp[idx].
- SHOW phase with en[idx] = 0: all anodes off and cathode off; the slot timing is unchanged.
- Hex decode, segments lit (active-high view gfedcba):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - With ACTIVE_LOW=1 the whole 8-bit cathode is inverted.
- load copies all three inputs into the pending buffer on the strobe cycle. A later load before commit overwrites pending.
- Commit: on the cycle frame_done = 1 (idx = NUM_DIGITS-1, count = DIV-1), pending is copied to active. If load coincides with that cycle, the values on the inputs in that cycle go straight to active and into pending.
- Active changes only at frame boundaries, so every frame shows a single coherent snapshot.
- frame_done pulses high for exactly one cycle every NUM_DIGITS*DIV cycles. First pulse occurs at cycle NUM_DIGITS*DIV-1 after reset release.
- Reset asserted mid-slot forces outputs off immediately (async) and discards pending data.

Test Plan:
- Sim params: NUM_DIGITS=4, CLK_HZ=1600, REFRESH_HZ=100, BLANK_CYCLES=2, ACTIVE_LOW=1 (DIV=4, frame = 16 cycles).
- Reset, then hold load=0 -> anode=4'hF and cathode=8'hFF on every cycle; frame_done pulses at cycles 15, 31, 47.
- load once with digits_in=16'h1A80, dp_in=4'b0100, en_in=4'hF, then run one frame -> values appear only after the next frame_done.
  - In the following frame, per slot: cycles 0-1 dark, cycles 2-3 show the digit.
  - digit0: anode=4'hE, cathode=8'hC0.
  - digit1: anode=4'hD, cathode=8'h80.
  - digit2: anode=4'hB, cathode=8'h08 (A with dp).
  - digit3: anode=4'h7, cathode=8'hF9.
- en_in=4'b1010 loaded with the same digits -> slots 0 and 2 stay anode=4'hF / cathode=8'hFF; slots 1 and 3 behave as in the previous scenario; frame still 16 cycles.
- Two loads in one frame (16'h1111, then 16'h2222), then a load coinciding with frame_done carrying 16'h3333 -> the next frame shows only 3s; 1s and 2s are never displayed.
- Assert rst in the SHOW phase of slot 2 -> the same cycle gives anode=4'hF and cathode=8'hFF; after release the scan restarts at digit 0 and stays dark until a new load commits.
- Sweep all 16 nibbles on digit0 -> cathode matches the decode table inverted; anode is never multi-hot in any cycle.
